mux_4x1_rr: RTL and testbench
=============================

Name: mux_4x1_rr

Overview:
- Four-channel round-robin multiplexer with valid/ready handshakes on every port.
- Merges four independent producer channels into one registered output stream.
- Tags each beat with its 2-bit source index on out_sel, so a downstream 1-to-4 demultiplexer can route it back with out_sel as its select.
- Sits on the gather side of the datapath, opposite the 1-to-4 scatter path.

Parameters:
- WIDTH, 8, data width of every input channel and the output.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low (sampled on rising clk edge only).
- in_valid  input  4  bit i: channel i presents a beat.
- in_data  input  4*WIDTH  channel i data in bits [i*WIDTH +: WIDTH].
- in_ready  output  4  bit i: channel i beat is accepted this cycle (combinational).
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data of the held beat.
- out_sel  output  2  registered source channel index of the held beat.
- out_ready  input  1  consumer accepts the held beat this cycle.

Behaviour:
- Reset (rst_n low at clk edge):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=0.
  - in_ready=0 for the whole cycle rst_n is low, regardless of other inputs.
  - Reset mid-transfer discards the held beat; the consumer does not see it.
- State:
  - 2-bit ptr names the highest-priority channel.
  - Output register is either EMPTY (out_valid=0) or FULL (out_valid=1).
- Load enable: load = !out_valid | out_ready.
- Arbitration (combinational, only when load=1):
  - Search in_valid in order ptr, ptr+1, ptr+2, ptr+3, modulo 4.
  - The first set bit is grant g.
  - in_ready has exactly one bit set (bit g). If no in_valid bit is set, in_ready=0.
- When load=1 and g exists, at the clock edge:
  - out_data <= channel g data, out_sel <= g, out_valid <= 1.
  - ptr <= (g+1) mod 4; wrap from 3 to 0.
- When load=1 and no in_valid bit is set: out_valid <= 0; out_data and out_sel hold their previous values; ptr holds.
- When load=0 (out_valid=1, out_ready=0):
  - in_ready=0, all registers hold.
  - out_data and out_sel stay stable until accepted.
- Latency and throughput:
  - One cycle from input acceptance to out_valid.
  - Full throughput of one beat per cycle when out_ready is held high.
  - A simultaneous consume and refill in the same cycle produces no bubble.
- in_ready must not depend on in_data. It may depend combinationally on in_valid, out_valid, out_ready and rst_n.
- Producers keep in_valid and in_data stable until in_ready. Dropping in_valid before acceptance is allowed and simply removes that channel from arbitration.
- Fairness: with all four channels continuously valid and out_ready=1, grants cycle 0,1,2,3,0,…. No channel waits more than 3 grants once valid.
- ptr changes only on a grant; idle cycles do not advance it.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles with in_valid=4'b1111 → in_ready=0, out_valid=0, out_data=0, out_sel=0. Release rst_n with in_valid=0 → outputs stay 0.
- Single channel: in_valid=4'b0100, ch2 data=8'hA5, out_ready=1 → in_ready=4'b0100 that cycle. Next cycle out_valid=1, out_data=8'hA5, out_sel=2. Following cycle, with in_valid=0, out_valid=0.
- Round-robin fairness: all channels valid with data 8'h10/8'h11/8'h12/8'h13, out_ready=1 for 8 cycles → out_sel sequence 0,1,2,3,0,1,2,3 and out_data matching, one beat per cycle.
- Backpressure: ch1=8'h3C accepted, then out_ready=0 for 3 cycles while in_valid=4'b1001 → out_data=8'h3C and out_sel=1 held, in_ready=0. When out_ready=1, ch3 is granted first (ptr=2), then ch0.
- Pointer wrap and skip: only ch3 and ch1 valid, ptr=0 → grants 1, 3, 1, 3; ptr after ch3 grant equals 0.
- Reset mid-operation: out_valid=1 with out_ready=0, then pull rst_n low for one cycle → next cycle out_valid=0 and ptr=0. The first grant after release goes to the lowest-index valid channel.

Source files
------------

// File: rtl/mux_4x1_rr.sv
// Four-channel round-robin merge into one registered, source-tagged output stream.
// Latency: one cycle from input acceptance to out_valid; one beat per cycle when out_ready stays high.
// Backpressure: while a held beat is not accepted, all in_ready are low and the output holds.
module mux_4x1_rr #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         in_valid,
    input  logic [4*WIDTH-1:0] in_data,
    output logic [3:0]         in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_sel,
    input  logic               out_ready
);

    logic [1:0]       ptr_q, ptr_d;
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] dat_q, dat_d;
    logic [1:0]       sel_q, sel_d;

    logic             load;
    logic             gnt_vld;
    logic [1:0]       gnt;
    logic [1:0]       idx;
    logic [WIDTH-1:0] gnt_dat;

    // The output register can take a new beat when empty or being drained this cycle.
    assign load = !vld_q || out_ready;

    // Search starts at ptr and wraps; the first requesting channel wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = 2'd0;
        idx     = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!gnt_vld && in_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt     = idx;
            end
        end
    end

    assign gnt_dat = in_data[gnt*WIDTH +: WIDTH];

    always_comb begin
        in_ready = 4'b0000;
        if (rst_n && load && gnt_vld) begin
            in_ready = 4'b0001 << gnt;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        vld_d = vld_q;
        dat_d = dat_q;
        sel_d = sel_q;
        if (load) begin
            if (gnt_vld) begin
                vld_d = 1'b1;
                dat_d = gnt_dat;
                sel_d = gnt;
                ptr_d = gnt + 2'd1;
            end else begin
                vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 2'd0;
            vld_q <= 1'b0;
            dat_q <= '0;
            sel_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
            vld_q <= vld_d;
            dat_q <= dat_d;
            sel_q <= sel_d;
        end
    end

    assign out_valid = vld_q;
    assign out_data  = dat_q;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_mux_4x1_rr.sv
// Bench for mux_4x1_rr: directed scenarios with literal expectations, then randomized traffic,
// all checked every cycle against a behavioural round-robin model.
module tb_mux_4x1_rr;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [3:0]     in_valid = 4'b0000;
    logic [4*W-1:0] in_data = '0;
    logic [3:0]     in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    mux_4x1_rr #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sel(out_sel), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    bit         armed = 1'b0;
    int         m_ptr = 0;
    bit         m_vld = 1'b0;
    logic [W-1:0] m_dat = '0;
    int         m_sel = 0;
    logic [3:0] acc = 4'b0000;

    function automatic int pick(int p, logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        int g;
        if (!rst_n) return 4'b0000;
        if (m_vld && !out_ready) return 4'b0000;
        g = pick(m_ptr, in_valid);
        if (g < 0) return 4'b0000;
        return 4'(1 << g);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int g;
        acc = 4'b0000;
        if (!rst_n) begin
            m_vld = 1'b0; m_dat = '0; m_sel = 0; m_ptr = 0;
            armed = 1'b1;
        end else if (!m_vld || out_ready) begin
            g = pick(m_ptr, in_valid);
            if (g >= 0) begin
                m_vld = 1'b1;
                m_dat = in_data[g*W +: W];
                m_sel = g;
                m_ptr = (g + 1) % 4;
                acc[g] = 1'b1;
            end else begin
                m_vld = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("model_in_ready", 32'(in_ready), 32'(exp_ready()));
            chk("model_out_valid", 32'(out_valid), 32'(m_vld));
            chk("model_out_data", 32'(out_data), 32'(m_dat));
            chk("model_out_sel", 32'(out_sel), 32'(m_sel));
        end
    end

    task automatic step(input logic r, input logic [3:0] v, input logic [4*W-1:0] d, input logic o);
        @(posedge clk);
        #1;
        rst_n = r; in_valid = v; in_data = d; out_ready = o;
        @(negedge clk);
    endtask

    localparam logic [4*W-1:0] ALL = {8'h13, 8'h12, 8'h11, 8'h10};

    initial begin
        logic [3:0]     v;
        logic [4*W-1:0] d;
        // Reset with every channel requesting
        step(1'b0, 4'b1111, ALL, 1'b1);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        step(1'b0, 4'b1111, ALL, 1'b1);
        chk("rst_in_ready2", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_sel", 32'(out_sel), 32'h0);
        step(1'b1, 4'b0000, '0, 1'b1);
        chk("idle_out_valid", 32'(out_valid), 32'h0);

        // Single channel 2
        step(1'b1, 4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00}, 1'b1);
        chk("single_in_ready", 32'(in_ready), 32'h4);
        step(1'b1, 4'b0000, '0, 1'b1);
        chk("single_out_valid", 32'(out_valid), 32'h1);
        chk("single_out_data", 32'(out_data), 32'hA5);
        chk("single_out_sel", 32'(out_sel), 32'h2);
        step(1'b1, 4'b0000, '0, 1'b1);
        chk("single_drain", 32'(out_valid), 32'h0);

        // Fairness from ptr=0
        step(1'b0, 4'b0000, '0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, (i < 8) ? 4'b1111 : 4'b0000, ALL, 1'b1);
            if (i < 8) chk("rr_in_ready", 32'(in_ready), 32'(1 << (i % 4)));
            if (i > 0) begin
                chk("rr_out_sel", 32'(out_sel), 32'((i - 1) % 4));
                chk("rr_out_data", 32'(out_data), 32'(8'h10 + (i - 1) % 4));
                chk("rr_out_valid", 32'(out_valid), 32'h1);
            end
        end

        // Backpressure: ch1 held, then ch3 before ch0
        step(1'b1, 4'b0010, {8'h00, 8'h00, 8'h3C, 8'h00}, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'b1001, {8'hD3, 8'h00, 8'h00, 8'hD0}, 1'b0);
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            chk("bp_out_data", 32'(out_data), 32'h3C);
            chk("bp_out_sel", 32'(out_sel), 32'h1);
        end
        step(1'b1, 4'b1001, {8'hD3, 8'h00, 8'h00, 8'hD0}, 1'b1);
        chk("bp_release_grant", 32'(in_ready), 32'h8);
        step(1'b1, 4'b0001, {8'h00, 8'h00, 8'h00, 8'hD0}, 1'b1);
        chk("bp_ch3_sel", 32'(out_sel), 32'h3);
        chk("bp_ch3_data", 32'(out_data), 32'hD3);
        chk("bp_ch0_grant", 32'(in_ready), 32'h1);
        step(1'b1, 4'b0000, '0, 1'b1);
        chk("bp_ch0_sel", 32'(out_sel), 32'h0);

        // Skip and wrap with ch1/ch3 only
        step(1'b0, 4'b0000, '0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'b1010, {8'hB3, 8'h00, 8'hB1, 8'h00}, 1'b1);
            chk("skip_grant", 32'(in_ready), (i % 2 == 0) ? 32'h2 : 32'h8);
        end
        step(1'b1, 4'b1111, ALL, 1'b1);
        chk("wrap_ptr0", 32'(in_ready), 32'h1);

        // Reset while holding a beat
        step(1'b1, 4'b0000, '0, 1'b0);
        step(1'b1, 4'b0000, '0, 1'b0);
        chk("mid_held", 32'(out_valid), 32'h1);
        step(1'b0, 4'b1111, ALL, 1'b0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
        step(1'b1, 4'b1010, {8'hC3, 8'h00, 8'hC1, 8'h00}, 1'b1);
        chk("mid_discard", 32'(out_valid), 32'h0);
        chk("mid_first_grant", 32'(in_ready), 32'h2);

        // Randomized traffic; pending beats stay stable unless occasionally withdrawn
        v = 4'b1010;
        d = {8'hC3, 8'h00, 8'hC1, 8'h00};
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            for (int c = 0; c < 4; c++) begin
                if (!(v[c] && !acc[c] && rst_n && ($urandom_range(15) != 0))) begin
                    v[c] = ($urandom_range(9) < 6);
                    d[c*W +: W] = 8'($urandom);
                end
            end
            rst_n = ($urandom_range(199) != 0);
            in_valid = v;
            in_data = d;
            out_ready = ($urandom_range(3) != 0);
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
